// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: ALU opcodes, field widths
// and the illegal-opcode test used by the decode/execute boundary.
package mips_pkg;

  localparam int OPCODE_W   = 4;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [OPCODE_W-1:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    XOR  = 4'b0100,
    NOR  = 4'b0101,
    SLT  = 4'b0110,
    SLTU = 4'b0111,
    SLL  = 4'b1000,
    SRL  = 4'b1001,
    SRA  = 4'b1010
  } alu_op_e;

  localparam alu_op_e LAST_LEGAL_OP = SRA;

  // Only a valid instruction can raise the illegal-opcode pulse.
  function automatic logic is_illegal(input logic valid, input logic [OPCODE_W-1:0] opcode);
    return valid && (opcode > LAST_LEGAL_OP);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: register-number compare against
// EX/MEM and MEM/WB, with the younger EX/MEM result taking priority.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int width = 8
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [width-1:0]      src_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [width-1:0]      exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [width-1:0]      memwb_result,
  output logic [width-1:0]      fwd_data
);

  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hard-wired to zero, so a write to it is never a forwarding source.
  assign exmem_hit = exmem_reg_write && (exmem_rd_addr == src_addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd_addr == src_addr);

  always_comb begin
    if (src_addr == REG_ZERO)
      fwd_data = '0;
    else if (exmem_hit)
      fwd_data = exmem_result;
    else if (memwb_hit)
      fwd_data = memwb_result;
    else
      fwd_data = src_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with forwarding applied,
// and supports stall, flush and illegal-opcode bubble insertion.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [width-1:0]      id_rs_data,
  input  logic [width-1:0]      id_rt_data,
  input  logic [width-1:0]      id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_reg_write,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [width-1:0]      exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [width-1:0]      memwb_result,
  output logic                  ex_valid,
  output logic [OPCODE_W-1:0]   ex_opcode,
  output logic [width-1:0]      ex_data_a,
  output logic [width-1:0]      ex_data_b,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
);

  logic [width-1:0] fwd_a;
  logic [width-1:0] fwd_b;

  fwd_mux #(.width(width)) u_fwd_a (
    .src_addr        (id_rs_addr),
    .src_data        (id_rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_a)
  );

  fwd_mux #(.width(width)) u_fwd_b (
    .src_addr        (id_rt_addr),
    .src_data        (id_rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_b)
  );

  logic                  nxt_valid;
  logic [OPCODE_W-1:0]   nxt_opcode;
  logic [width-1:0]      nxt_data_a;
  logic [width-1:0]      nxt_data_b;
  logic [REG_ADDR_W-1:0] nxt_rd_addr;
  logic                  nxt_reg_write;
  logic                  nxt_illegal;

  // Priority: flush > illegal opcode > stall > load. An illegal opcode
  // overrides stall so the exception pulse is never lost.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    nxt_valid     = ex_valid;
    nxt_opcode    = ex_opcode;
    nxt_data_a    = ex_data_a;
    nxt_data_b    = ex_data_b;
    nxt_rd_addr   = ex_rd_addr;
    nxt_reg_write = ex_reg_write;
    nxt_illegal   = 1'b0;

    if (flush || is_illegal(id_valid, id_opcode)) begin
      nxt_valid     = 1'b0;
      nxt_opcode    = ADD;
      nxt_data_a    = '0;
      nxt_data_b    = '0;
      nxt_rd_addr   = REG_ZERO;
      nxt_reg_write = 1'b0;
      nxt_illegal   = !flush;
    end else if (!stall) begin
      nxt_valid     = id_valid;
      nxt_opcode    = id_opcode;
      nxt_data_a    = fwd_a;
      nxt_data_b    = id_use_imm ? id_imm : fwd_b;
      nxt_rd_addr   = id_rd_addr;
      nxt_reg_write = id_reg_write && id_valid;
    end
  end

  // NOTE: the stage is a handful of control/data flops, not a memory, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= ADD;
      ex_data_a    <= '0;
      ex_data_b    <= '0;
      ex_rd_addr   <= REG_ZERO;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      ex_valid     <= nxt_valid;
      ex_opcode    <= nxt_opcode;
      ex_data_a    <= nxt_data_a;
      ex_data_b    <= nxt_data_b;
      ex_rd_addr   <= nxt_rd_addr;
      ex_reg_write <= nxt_reg_write;
      ex_illegal   <= nxt_illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (width=8): vector table for forwarding, stall,
// flush and illegal-opcode behaviour, plus hand sequences for async reset.
module tb_id_ex_stage;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         stall, flush;
  logic         id_valid;
  logic [3:0]   id_opcode;
  logic [4:0]   id_rs_addr, id_rt_addr, id_rd_addr;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm;
  logic         id_use_imm, id_reg_write;
  logic         exmem_reg_write;
  logic [4:0]   exmem_rd_addr;
  logic [W-1:0] exmem_result;
  logic         memwb_reg_write;
  logic [4:0]   memwb_rd_addr;
  logic [W-1:0] memwb_result;
  logic         ex_valid;
  logic [3:0]   ex_opcode;
  logic [W-1:0] ex_data_a, ex_data_b;
  logic [4:0]   ex_rd_addr;
  logic         ex_reg_write;
  logic         ex_illegal;

  id_ex_stage #(.width(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_rd_addr      (id_rd_addr),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_use_imm      (id_use_imm),
    .id_reg_write    (id_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .ex_opcode       (ex_opcode),
    .ex_data_a       (ex_data_a),
    .ex_data_b       (ex_data_b),
    .ex_rd_addr      (ex_rd_addr),
    .ex_reg_write    (ex_reg_write),
    .ex_illegal      (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         st;
    logic         fl;
    logic         v;
    logic [3:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [W-1:0] rsd;
    logic [W-1:0] rtd;
    logic [W-1:0] imm;
    logic         ui;
    logic         rw;
    logic         xw;
    logic [4:0]   xrd;
    logic [W-1:0] xres;
    logic         ww;
    logic [4:0]   wrd;
    logic [W-1:0] wres;
    logic         e_valid;
    logic [3:0]   e_op;
    logic [W-1:0] e_a;
    logic [W-1:0] e_b;
    logic [4:0]   e_rd;
    logic         e_rw;
    logic         e_ill;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] rd, input logic rw, input logic ill);
    check({tag, ".ex_valid"},     32'(ex_valid),     32'(v));
    check({tag, ".ex_opcode"},    32'(ex_opcode),    32'(op));
    check({tag, ".ex_data_a"},    32'(ex_data_a),    32'(a));
    check({tag, ".ex_data_b"},    32'(ex_data_b),    32'(b));
    check({tag, ".ex_rd_addr"},   32'(ex_rd_addr),   32'(rd));
    check({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(rw));
    check({tag, ".ex_illegal"},   32'(ex_illegal),   32'(ill));
  endtask

  task automatic drive(input vec_t t);
    stall           = t.st;
    flush           = t.fl;
    id_valid        = t.v;
    id_opcode       = t.op;
    id_rs_addr      = t.rs;
    id_rt_addr      = t.rt;
    id_rd_addr      = t.rd;
    id_rs_data      = t.rsd;
    id_rt_data      = t.rtd;
    id_imm          = t.imm;
    id_use_imm      = t.ui;
    id_reg_write    = t.rw;
    exmem_reg_write = t.xw;
    exmem_rd_addr   = t.xrd;
    exmem_result    = t.xres;
    memwb_reg_write = t.ww;
    memwb_rd_addr   = t.wrd;
    memwb_result    = t.wres;
  endtask

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    vec_t idle;
    // Fields: st fl v op rs rt rd rsd rtd imm ui rw | xw xrd xres | ww wrd wres | exp v op a b rd rw ill
    vecs[0]  = '{1'b0,1'b0,1'b1,4'h0,5'd3,5'd4,5'd5,8'h10,8'h05,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,4'h0,8'h10,8'h05,5'd5,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,4'h1,5'd7,5'd7,5'd8,8'h01,8'h02,8'h00,1'b0,1'b1, 1'b1,5'd7,8'hAA, 1'b1,5'd7,8'h55, 1'b1,4'h1,8'hAA,8'hAA,5'd8,1'b1,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,4'h1,5'd7,5'd7,5'd8,8'h01,8'h02,8'h00,1'b0,1'b1, 1'b0,5'd7,8'hAA, 1'b1,5'd7,8'h55, 1'b1,4'h1,8'h55,8'h55,5'd8,1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,4'h2,5'd0,5'd2,5'd9,8'h33,8'h44,8'h00,1'b0,1'b1, 1'b1,5'd0,8'hFF, 1'b1,5'd0,8'h77, 1'b1,4'h2,8'h00,8'h44,5'd9,1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,4'h6,5'd9,5'd9,5'd10,8'h01,8'h02,8'h80,1'b1,1'b1, 1'b1,5'd9,8'hAA, 1'b0,5'd0,8'h00, 1'b1,4'h6,8'hAA,8'h80,5'd10,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,4'h0,5'd1,5'd1,5'd3,8'h11,8'h22,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h11,8'h22,5'd3,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,4'hA,5'd2,5'd3,5'd4,8'h5A,8'hA5,8'h00,1'b0,1'b0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,4'hA,8'h5A,8'hA5,5'd4,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,4'hB,5'd2,5'd3,5'd4,8'h5A,8'hA5,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h00,8'h00,5'd0,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,4'hF,5'd1,5'd2,5'd6,8'h12,8'h34,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'hF,8'h12,8'h34,5'd6,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,4'h1,5'd3,5'd4,5'd10,8'h21,8'h43,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,4'h1,8'h21,8'h43,5'd10,1'b1,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,4'h0,5'd5,5'd6,5'd11,8'h99,8'h88,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,4'h1,8'h21,8'h43,5'd10,1'b1,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b1,4'h0,5'd5,5'd6,5'd11,8'h99,8'h88,8'h00,1'b0,1'b1, 1'b1,5'd5,8'hCC, 1'b0,5'd0,8'h00, 1'b1,4'h1,8'h21,8'h43,5'd10,1'b1,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,4'h3,5'd5,5'd6,5'd12,8'h77,8'h66,8'hEE,1'b1,1'b0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b1,4'h1,8'h21,8'h43,5'd10,1'b1,1'b0};
    vecs[13] = '{1'b1,1'b1,1'b1,4'h2,5'd5,5'd6,5'd12,8'h77,8'h66,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h00,8'h00,5'd0,1'b0,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b1,4'hC,5'd3,5'd4,5'd7,8'h21,8'h43,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h00,8'h00,5'd0,1'b0,1'b1};
    vecs[15] = '{1'b1,1'b0,1'b1,4'h0,5'd3,5'd4,5'd7,8'h21,8'h43,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h00,8'h00,5'd0,1'b0,1'b0};
    vecs[16] = '{1'b0,1'b1,1'b1,4'hE,5'd3,5'd4,5'd7,8'h21,8'h43,8'h00,1'b0,1'b1, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 1'b0,4'h0,8'h00,8'h00,5'd0,1'b0,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b1,4'h4,5'd12,5'd13,5'd14,8'h01,8'h02,8'h00,1'b0,1'b1, 1'b1,5'd13,8'hC3, 1'b1,5'd12,8'h5A, 1'b1,4'h4,8'h5A,8'hC3,5'd14,1'b1,1'b0};

    idle = '0;
    drive(idle);
    rst_n = 1'b0;
    #2;
    check_all("reset", 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;  // released at t=12, between edges

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_op, vecs[i].e_a,
                vecs[i].e_b, vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_ill);
    end

    // Async reset mid-cycle during valid traffic, then normal load on the first edge.
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check_all("pre_rst", 1'b1, 4'h0, 8'h10, 8'h05, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_load", 1'b1, 4'h0, 8'h10, 8'h05, 5'd5, 1'b1, 1'b0);

    // Reset during a stall discards the held instruction.
    drive(vecs[10]);
    @(posedge clk);
    #1;
    check_all("stall_hold", 1'b1, 4'h0, 8'h10, 8'h05, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("stall_rst.ex_valid", 32'(ex_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("stall_after_rst", 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one parameter: width, default 8, data-path width in bits of every operand and result port.
REQ-002 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- id_valid  in  1  decode slot holds an instruction
- id_opcode  in  4  ALU opcode from decode
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  source and destination register numbers
- id_rs_data, id_rt_data  in  width each  register-file read data
- id_imm  in  width  sign-extended immediate
- id_use_imm  in  1  operand B takes id_imm
- id_reg_write  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM writes back
- exmem_rd_addr  in  5  EX/MEM destination
- exmem_result  in  width  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writes back
- memwb_rd_addr  in  5  MEM/WB destination
- memwb_result  in  width  MEM/WB result
- ex_valid  out  1  EX slot holds an instruction
- ex_opcode  out  4  opcode to ALU
- ex_data_a, ex_data_b  out  width each  operands to ALU
- ex_rd_addr  out  5  destination carried to EX
- ex_reg_write  out  1  write-back enable carried to EX
- ex_illegal  out  1  one-cycle illegal-opcode pulse

Function
REQ-004 All outputs SHALL be registered; latency from decode inputs to ex_* is exactly one clk cycle.
REQ-005 Per-edge priority SHALL be flush > illegal-opcode > stall > load.
REQ-006 Load (stall=0, flush=0): ex_valid<=id_valid; ex_opcode<=id_opcode; ex_rd_addr<=id_rd_addr; ex_reg_write<=id_reg_write&id_valid; ex_data_a<=fwdA; ex_data_b<=id_use_imm ? id_imm : fwdB.
REQ-007 fwdA SHALL be 0 if id_rs_addr==0; else exmem_result if exmem_reg_write and exmem_rd_addr==id_rs_addr; else memwb_result if memwb_reg_write and memwb_rd_addr==id_rs_addr; else id_rs_data.
REQ-008 fwdB SHALL follow the REQ-007 rule using id_rt_addr/id_rt_data; EX/MEM always wins over MEM/WB on double match.
REQ-009 A destination of register 0 SHALL never forward, even with reg_write set.
REQ-010 Stall (flush=0): every output register SHALL hold its value; ex_illegal SHALL be 0.
REQ-011 Flush: ex_valid=0, ex_reg_write=0, ex_opcode=4'b0000, ex_data_a=ex_data_b=0, ex_rd_addr=0, ex_illegal=0, regardless of stall.
REQ-012 id_valid=1 with id_opcode in 4'b1011..4'b1111 and flush=0 SHALL load a bubble (per REQ-011) and set ex_illegal=1 for exactly that cycle, even when stall=1.
REQ-013 Legal opcodes 4'b0000..4'b1010 SHALL pass through unchanged; id_valid=0 loads a non-writing entry with no illegal pulse.
REQ-014 No arithmetic SHALL be performed; operand values pass bit-exact at width bits.

Reset
REQ-015 rst_n low SHALL immediately clear all outputs to the REQ-011 bubble values with ex_illegal=0, independent of clk.
REQ-016 The first rising clk edge after rst_n rises SHALL perform a normal load per REQ-005; reset asserted mid-stall SHALL discard the held instruction.

Structure
REQ-017 Package mips_pkg SHALL hold: ALU opcode constants (ADD=0000 .. SRA=1010), OPCODE_W=4, REG_ADDR_W=5, REG_ZERO=5'd0, and the last legal opcode value.
REQ-018 One sub-module, fwd_mux (register-number compare plus priority select for one operand), SHALL be instantiated twice, once for A and once for B.

Verification (width=8)
REQ-019 ADD, rs=3 (data 0x10), rt=4 (data 0x05), no forwarding, id_valid=1 -> next cycle ex_data_a=0x10, ex_data_b=0x05, ex_opcode=0000, ex_valid=1.
REQ-020 rs=rt=7, exmem (rd=7, 0xAA, we=1), memwb (rd=7, 0x55, we=1) -> ex_data_a=ex_data_b=0xAA; then exmem we=0 -> both 0x55.
REQ-021 rs=0, exmem rd=0 with we=1 and result 0xFF, id_rs_data=0x33 -> ex_data_a=0x00.
REQ-022 Load SUB, then stall=1 for 3 cycles while inputs change -> outputs unchanged; stall=1 with flush=1 -> bubble, ex_valid=0.
REQ-023 id_opcode=4'b1100, id_valid=1, stall=1 -> one cycle of ex_illegal=1, ex_valid=0, ex_reg_write=0; next cycle ex_illegal=0.
REQ-024 rst_n pulsed low between clk edges during valid traffic -> outputs reach bubble values before the next edge.
